// File: rtl/id_stage_pipe.sv
// id_stage_pipe: OpenMIPS decode stage with ID/EX register, EX/MEM forwarding and valid/ready flow control.
// Define ID_SHIFT_EN to decode SLL/SRL/SRA; without it those encodings are reported invalid.
module id_stage_pipe #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [PC_W-1:0]   pc_i,
    input  logic [31:0]       inst_i,
    output logic              reg1_read_o,
    output logic [4:0]        reg1_addr_o,
    input  logic [DATA_W-1:0] reg1_data_i,
    output logic              reg2_read_o,
    output logic [4:0]        reg2_addr_o,
    input  logic [DATA_W-1:0] reg2_data_i,
    input  logic              ex_wreg_i,
    input  logic [4:0]        ex_wd_i,
    input  logic [DATA_W-1:0] ex_wdata_i,
    input  logic              mem_wreg_i,
    input  logic [4:0]        mem_wd_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [PC_W-1:0]   pc_o,
    output logic [7:0]        aluop_o,
    output logic [2:0]        alusel_o,
    output logic [DATA_W-1:0] reg1_o,
    output logic [DATA_W-1:0] reg2_o,
    output logic [4:0]        wd_o,
    output logic              wreg_o,
    output logic              invalid_o
);
    localparam logic [2:0] SEL_NOP   = 3'b000;
    localparam logic [2:0] SEL_LOGIC = 3'b001;
    localparam logic [7:0] OP_NOP    = 8'h00;
    localparam logic [7:0] OP_AND    = 8'h24;
    localparam logic [7:0] OP_OR     = 8'h25;
    localparam logic [7:0] OP_XOR    = 8'h26;
`ifdef ID_SHIFT_EN
    localparam logic [2:0] SEL_SHIFT = 3'b010;
    localparam logic [7:0] OP_SLL    = 8'h7C;
    localparam logic [7:0] OP_SRL    = 8'h02;
    localparam logic [7:0] OP_SRA    = 8'h03;
`endif

    logic [5:0] op, funct;
    logic [4:0] rs, rt, rd, shamt;
    assign op    = inst_i[31:26];
    assign rs    = inst_i[25:21];
    assign rt    = inst_i[20:16];
    assign rd    = inst_i[15:11];
    assign shamt = inst_i[10:6];
    assign funct = inst_i[5:0];

    logic              rd1, rd2, lui, wr, invalid_d;
    logic [7:0]        aluop_d;
    logic [2:0]        alusel_d;
    logic [4:0]        wd_d;
    logic [DATA_W-1:0] imm1, imm2, reg1_d, reg2_d;

    always_comb begin
        rd1       = 1'b0;
        rd2       = 1'b0;
        lui       = 1'b0;
        wr        = 1'b0;
        invalid_d = 1'b1;
        aluop_d   = OP_NOP;
        alusel_d  = SEL_NOP;
        wd_d      = 5'd0;
        imm1      = '0;
        imm2      = '0;
        case (op)
            6'h0c, 6'h0d, 6'h0e: begin
                rd1       = 1'b1;
                wr        = 1'b1;
                invalid_d = 1'b0;
                alusel_d  = SEL_LOGIC;
                aluop_d   = op == 6'h0c ? OP_AND : op == 6'h0d ? OP_OR : OP_XOR;
                wd_d      = rt;
                imm2      = DATA_W'(inst_i[15:0]);
            end
            6'h0f: begin
                rd1       = 1'b1;
                lui       = 1'b1;
                wr        = 1'b1;
                invalid_d = 1'b0;
                alusel_d  = SEL_LOGIC;
                aluop_d   = OP_OR;
                wd_d      = rt;
                imm2      = DATA_W'({inst_i[15:0], 16'h0000});
            end
            6'h00: begin
                // funct 0x24..0x27 share the upper bits 1001 and map directly onto the aluop codes
                if (shamt == 5'd0 && funct[5:2] == 4'b1001) begin
                    rd1       = 1'b1;
                    rd2       = 1'b1;
                    wr        = 1'b1;
                    invalid_d = 1'b0;
                    alusel_d  = SEL_LOGIC;
                    aluop_d   = {2'b00, funct};
                    wd_d      = rd;
                end
`ifdef ID_SHIFT_EN
                else if (rs == 5'd0 && (funct == 6'h00 || funct == 6'h02 || funct == 6'h03)) begin
                    rd2       = 1'b1;
                    wr        = 1'b1;
                    invalid_d = 1'b0;
                    alusel_d  = SEL_SHIFT;
                    aluop_d   = funct == 6'h00 ? OP_SLL : funct == 6'h02 ? OP_SRL : OP_SRA;
                    wd_d      = rd;
                    imm1      = DATA_W'(shamt);
                end
`endif
            end
            default: ;
        endcase
    end

    function automatic logic [DATA_W-1:0] operand(
        input logic rd_en, input logic [4:0] a, input logic [DATA_W-1:0] imm, input logic [DATA_W-1:0] rf,
        input logic exw, input logic [4:0] exa, input logic [DATA_W-1:0] exd,
        input logic mw, input logic [4:0] ma, input logic [DATA_W-1:0] md);
        return !rd_en ? imm : a == 5'd0 ? '0 : (exw && exa == a) ? exd : (mw && ma == a) ? md : rf;
    endfunction

    assign reg1_d = lui ? '0 : operand(rd1, rs, imm1, reg1_data_i, ex_wreg_i, ex_wd_i, ex_wdata_i,
                                       mem_wreg_i, mem_wd_i, mem_wdata_i);
    assign reg2_d = operand(rd2, rt, imm2, reg2_data_i, ex_wreg_i, ex_wd_i, ex_wdata_i,
                            mem_wreg_i, mem_wd_i, mem_wdata_i);

    assign reg1_read_o = !rst && rd1;
    assign reg2_read_o = !rst && rd2;
    assign reg1_addr_o = rst ? 5'd0 : rs;
    assign reg2_addr_o = rst ? 5'd0 : rt;

    logic              valid_q, valid_d, cap;
    logic [PC_W-1:0]   pc_q;
    logic [7:0]        aluop_q;
    logic [2:0]        alusel_q;
    logic [DATA_W-1:0] reg1_q, reg2_q;
    logic [4:0]        wd_q;
    logic              wreg_q, invalid_q;

    assign in_ready_o = !flush_i && (!valid_q || out_ready_i);
    assign cap        = in_valid_i && in_ready_o;
    assign valid_d    = cap || (valid_q && !flush_i && !out_ready_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            pc_q      <= '0;
            aluop_q   <= OP_NOP;
            alusel_q  <= SEL_NOP;
            reg1_q    <= '0;
            reg2_q    <= '0;
            wd_q      <= 5'd0;
            wreg_q    <= 1'b0;
            invalid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            if (cap) begin
                pc_q      <= pc_i;
                aluop_q   <= aluop_d;
                alusel_q  <= alusel_d;
                reg1_q    <= reg1_d;
                reg2_q    <= reg2_d;
                wd_q      <= wd_d;
                wreg_q    <= wr && wd_d != 5'd0;
                invalid_q <= invalid_d;
            end
        end
    end

    assign out_valid_o = valid_q;
    assign pc_o        = pc_q;
    assign aluop_o     = aluop_q;
    assign alusel_o    = alusel_q;
    assign reg1_o      = reg1_q;
    assign reg2_o      = reg2_q;
    assign wd_o        = wd_q;
    assign wreg_o      = wreg_q;
    assign invalid_o   = invalid_q;
endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: directed vectors for id_stage_pipe checked against an instruction-level reference model.
module tb_id_stage_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] pc = '0, inst = '0;
    logic        ex_wreg = 1'b0, mem_wreg = 1'b0;
    logic [4:0]  ex_wd = '0, mem_wd = '0;
    logic [31:0] ex_wdata = '0, mem_wdata = '0;
    logic        in_ready, r1_read, r2_read, out_valid, wreg, invalid;
    logic [4:0]  r1_addr, r2_addr, wd;
    logic [31:0] r1_data, r2_data, pc_out, reg1, reg2;
    logic [7:0]  aluop;
    logic [2:0]  alusel;

    function automatic logic [31:0] rfv(input logic [4:0] a);
        return 32'hF000_0000 + 32'(a) * 32'h101;
    endfunction

    assign r1_data = rfv(r1_addr);
    assign r2_data = rfv(r2_addr);

    id_stage_pipe #(.DATA_W(32), .PC_W(32)) dut (
        .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .pc_i(pc), .inst_i(inst),
        .reg1_read_o(r1_read), .reg1_addr_o(r1_addr), .reg1_data_i(r1_data),
        .reg2_read_o(r2_read), .reg2_addr_o(r2_addr), .reg2_data_i(r2_data),
        .ex_wreg_i(ex_wreg), .ex_wd_i(ex_wd), .ex_wdata_i(ex_wdata),
        .mem_wreg_i(mem_wreg), .mem_wd_i(mem_wd), .mem_wdata_i(mem_wdata),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .pc_o(pc_out),
        .aluop_o(aluop), .alusel_o(alusel), .reg1_o(reg1), .reg2_o(reg2),
        .wd_o(wd), .wreg_o(wreg), .invalid_o(invalid)
    );

    typedef struct packed {
        logic        r1, r2;
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic [4:0]  wd;
        logic        wreg, inv;
        logic [31:0] o1, o2;
    } exp_t;

    function automatic logic [31:0] src(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (ex_wreg && ex_wd == a) return ex_wdata;
        if (mem_wreg && mem_wd == a) return mem_wdata;
        return rfv(a);
    endfunction

    function automatic exp_t dec(input logic [31:0] i);
        exp_t e;
        logic [5:0] o, f;
        o = i[31:26];
        f = i[5:0];
        e = '0;
        e.inv = 1'b1;
        if (o == 6'h0c || o == 6'h0d || o == 6'h0e) begin
            e.r1 = 1'b1; e.inv = 1'b0; e.wreg = 1'b1; e.alusel = 3'b001; e.wd = i[20:16];
            e.aluop = o == 6'h0c ? 8'h24 : o == 6'h0d ? 8'h25 : 8'h26;
            e.o1 = src(i[25:21]);
            e.o2 = {16'h0, i[15:0]};
        end else if (o == 6'h0f) begin
            e.r1 = 1'b1; e.inv = 1'b0; e.wreg = 1'b1; e.alusel = 3'b001; e.wd = i[20:16];
            e.aluop = 8'h25;
            e.o2 = {i[15:0], 16'h0};
        end else if (o == 6'h00 && i[10:6] == 5'd0 && f >= 6'h24 && f <= 6'h27) begin
            e.r1 = 1'b1; e.r2 = 1'b1; e.inv = 1'b0; e.wreg = 1'b1; e.alusel = 3'b001; e.wd = i[15:11];
            e.aluop = f == 6'h24 ? 8'h24 : f == 6'h25 ? 8'h25 : f == 6'h26 ? 8'h26 : 8'h27;
            e.o1 = src(i[25:21]);
            e.o2 = src(i[20:16]);
        end
`ifdef ID_SHIFT_EN
        else if (o == 6'h00 && i[25:21] == 5'd0 && (f == 6'h00 || f == 6'h02 || f == 6'h03)) begin
            e.r2 = 1'b1; e.inv = 1'b0; e.wreg = 1'b1; e.alusel = 3'b010; e.wd = i[15:11];
            e.aluop = f == 6'h00 ? 8'h7C : f == 6'h02 ? 8'h02 : 8'h03;
            e.o1 = {27'h0, i[10:6]};
            e.o2 = src(i[20:16]);
        end
`endif
        if (e.wd == 5'd0) e.wreg = 1'b0;
        return e;
    endfunction

    // Reference: one holding slot; accept when empty or being drained, drop on flush/drain.
    logic        mv = 1'b0;
    logic [31:0] mpc = '0;
    exp_t        me = '0;
    always @(posedge clk) begin
        if (rst) begin
            mv  <= 1'b0;
            mpc <= '0;
            me  <= '0;
        end else if (in_valid && !flush && (!mv || out_ready)) begin
            mv  <= 1'b1;
            mpc <= pc;
            me  <= dec(inst);
        end else if (flush || out_ready) begin
            mv <= 1'b0;
        end
    end

    int n_vec = 0, n_err = 0;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    logic go = 1'b0;
    always @(negedge clk) begin
        exp_t d;
        if (go) begin
            d = dec(inst);
            chk("out_valid", 64'(out_valid), 64'(mv));
            chk("in_ready", 64'(in_ready), 64'(!flush && (!mv || out_ready)));
            chk("reg1_read", 64'(r1_read), 64'(!rst && d.r1));
            chk("reg2_read", 64'(r2_read), 64'(!rst && d.r2));
            chk("reg1_addr", 64'(r1_addr), 64'(rst ? 5'd0 : inst[25:21]));
            chk("reg2_addr", 64'(r2_addr), 64'(rst ? 5'd0 : inst[20:16]));
            chk("pc", 64'(pc_out), 64'(mpc));
            chk("aluop", 64'(aluop), 64'(me.aluop));
            chk("alusel", 64'(alusel), 64'(me.alusel));
            chk("reg1", 64'(reg1), 64'(me.o1));
            chk("reg2", 64'(reg2), 64'(me.o2));
            chk("wd", 64'(wd), 64'(me.wd));
            chk("wreg", 64'(wreg), 64'(me.wreg));
            chk("invalid", 64'(invalid), 64'(me.inv));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] i, input logic [31:0] p, input logic v, input logic r, input logic f);
        inst = i;
        pc = p;
        in_valid = v;
        out_ready = r;
        flush = f;
        tick();
    endtask

    initial begin
        tick();
        go = 1'b1;
        tick();
        rst = 1'b0;
        chk("lit_rst_valid", 64'(out_valid), 64'(0));
        chk("lit_rst_aluop", 64'(aluop), 64'(8'h00));

        issue(32'h34011100, 32'h100, 1, 1, 0);
        chk("lit_ori_valid", 64'(out_valid), 64'(1));
        chk("lit_ori_aluop", 64'(aluop), 64'(8'h25));
        chk("lit_ori_alusel", 64'(alusel), 64'(3'b001));
        chk("lit_ori_reg1", 64'(reg1), 64'(0));
        chk("lit_ori_reg2", 64'(reg2), 64'(32'h00001100));
        chk("lit_ori_wd", 64'(wd), 64'(1));
        chk("lit_ori_wreg", 64'(wreg), 64'(1));

        ex_wreg = 1; ex_wd = 1; ex_wdata = 32'hAAAA0000;
        mem_wreg = 1; mem_wd = 1; mem_wdata = 32'h1;
        issue(32'h00221825, 32'h104, 1, 1, 0);
        chk("lit_or_reg1", 64'(reg1), 64'(32'hAAAA0000));
        chk("lit_or_reg2", 64'(reg2), 64'(32'hF0000202));
        chk("lit_or_wd", 64'(wd), 64'(3));

        ex_wreg = 0; ex_wd = 2; mem_wd = 3; mem_wdata = 32'h55;
        issue(32'h00432824, 32'h108, 1, 1, 0);
        chk("lit_and_reg1", 64'(reg1), 64'(32'hF0000202));
        chk("lit_and_reg2", 64'(reg2), 64'(32'h55));
        mem_wreg = 0;

        for (int k = 0; k < 3; k++) issue(32'h3826FFFF, 32'h10C, 1, 0, 0);
        chk("lit_stall_ready", 64'(in_ready), 64'(0));
        chk("lit_stall_wd", 64'(wd), 64'(5));
        issue(32'h3826FFFF, 32'h10C, 1, 1, 0);
        chk("lit_xori_wd", 64'(wd), 64'(6));
        chk("lit_xori_reg2", 64'(reg2), 64'(32'h0000FFFF));
        issue(32'h30C700F0, 32'h110, 1, 1, 0);

        issue(32'h00224027, 32'h114, 1, 1, 1);
        chk("lit_flush_valid", 64'(out_valid), 64'(0));
        chk("lit_flush_pc", 64'(pc_out), 64'(32'h110));
        issue(32'h00224027, 32'h114, 1, 1, 0);
        chk("lit_nor_aluop", 64'(aluop), 64'(8'h27));
        issue(32'h0, 32'h0, 0, 1, 0);

        issue(32'h34290007, 32'h118, 1, 0, 0);
        issue(32'h3C048000, 32'h11C, 1, 0, 0);
        chk("lit_hold_wd", 64'(wd), 64'(9));
        rst = 1;
        issue(32'h3C048000, 32'h11C, 1, 0, 0);
        rst = 0;
        chk("lit_rst2_valid", 64'(out_valid), 64'(0));
        chk("lit_rst2_pc", 64'(pc_out), 64'(0));
        chk("lit_rst2_reg2", 64'(reg2), 64'(0));

        issue(32'h3C048000, 32'h120, 1, 1, 0);
        chk("lit_lui_reg2", 64'(reg2), 64'(32'h80000000));
        chk("lit_lui_aluop", 64'(aluop), 64'(8'h25));
        ex_wreg = 1; ex_wd = 1;
        issue(32'h3C258000, 32'h124, 1, 1, 0);
        chk("lit_lui_fwd_reg1", 64'(reg1), 64'(0));
        ex_wreg = 0;
        issue(32'h34000005, 32'h128, 1, 1, 0);
        chk("lit_r0_wreg", 64'(wreg), 64'(0));

        issue(32'h00041080, 32'h12C, 1, 1, 0);
`ifdef ID_SHIFT_EN
        chk("lit_sll_aluop", 64'(aluop), 64'(8'h7C));
        chk("lit_sll_alusel", 64'(alusel), 64'(3'b010));
        chk("lit_sll_reg1", 64'(reg1), 64'(2));
        chk("lit_sll_wd", 64'(wd), 64'(2));
`else
        chk("lit_sll_invalid", 64'(invalid), 64'(1));
        chk("lit_sll_wreg", 64'(wreg), 64'(0));
`endif
        issue(32'h00000000, 32'h130, 1, 1, 0);
        chk("lit_nop_wreg", 64'(wreg), 64'(0));
        issue(32'h00041FC3, 32'h134, 1, 1, 0);
        issue(32'h00241082, 32'h138, 1, 1, 0);
        chk("lit_srl_rs_invalid", 64'(invalid), 64'(1));
        issue(32'hFC000000, 32'h13C, 1, 1, 0);
        issue(32'h00221865, 32'h140, 1, 1, 0);
        chk("lit_shamt_invalid", 64'(invalid), 64'(1));
        issue(32'h0, 32'h0, 0, 1, 0);
        issue(32'h0, 32'h0, 0, 1, 0);
        go = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
